swap_req_queue: RTL and testbench

- Buffers block-swap requests between the request-blocker controller and the block-swap controller, replacing the single-register hand-off stage.
- Stores up to Depth requests in order. Each request carries the SRAM slot index, the old block address and the new block address.
- Presents one request at a time to the swap engine with a level req/done handshake, and returns completion to the producer.
- Optionally drops duplicate requests for a block that is already queued.

---
 rtl/swap_req_queue.sv | 139 +++++++++++++
 tb/tb_swap_req_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_req_queue.sv
// In-order queue of block-swap requests between the request blocker and the swap engine.
// Define SWAP_QUEUE_DEDUP_EN to drop pushes whose new address is already queued.
module swap_req_queue #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned IdxWidth  = 3,
  parameter int unsigned AddrWidth = 21
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [IdxWidth-1:0]    push_idx_i,
  input  logic [AddrWidth-1:0]   push_old_addr_i,
  input  logic [AddrWidth-1:0]   push_new_addr_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   swap_req_o,
  output logic [IdxWidth-1:0]    old_addr_idx_o,
  output logic [AddrWidth-1:0]   old_addr_o,
  output logic [AddrWidth-1:0]   new_addr_o,
  input  logic                   done_i,
  output logic [$clog2(Depth):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic [IdxWidth-1:0]  head_idx_q, head_idx_d;
  logic [AddrWidth-1:0] head_old_q, head_old_d;
  logic [AddrWidth-1:0] head_new_q, head_new_d;

  logic [IdxWidth-1:0]  idx_mem_q [Depth];
  logic [AddrWidth-1:0] old_mem_q [Depth];
  logic [AddrWidth-1:0] new_mem_q [Depth];

  logic full, dup, push_ok, retire, head_load;

  assign full = (count_q == FullCount);

`ifdef SWAP_QUEUE_DEDUP_EN
  // Compares against registered entries only; the BUSY head is still counted as valid.
  always_comb begin
    dup = 1'b0;
    for (int unsigned k = 0; k < Depth; k++) begin
      if ((CntW'(k) < count_q) && (new_mem_q[rd_ptr_q + PtrW'(k)] == push_new_addr_i)) begin
        dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          head_load = 1'b1;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (done_i) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push_ok    = push_i & ~full & ~dup;
    // A full queue drops the push even when the head retires in the same cycle.
    overflow_d = overflow_q | (push_i & full & ~dup);
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = retire ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q + CntW'(push_ok) - CntW'(retire);
    done_d     = retire;
    head_idx_d = head_load ? idx_mem_q[rd_ptr_q] : head_idx_q;
    head_old_d = head_load ? old_mem_q[rd_ptr_q] : head_old_q;
    head_new_d = head_load ? new_mem_q[rd_ptr_q] : head_new_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      head_idx_q <= '0;
      head_old_q <= '0;
      head_new_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      head_idx_q <= head_idx_d;
      head_old_q <= head_old_d;
      head_new_q <= head_new_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      idx_mem_q[wr_ptr_q] <= push_idx_i;
      old_mem_q[wr_ptr_q] <= push_old_addr_i;
      new_mem_q[wr_ptr_q] <= push_new_addr_i;
    end
  end

  assign ready_o        = ~full;
  assign done_o         = done_q;
  assign swap_req_o     = (state_q == StBusy);
  assign old_addr_idx_o = head_idx_q;
  assign old_addr_o     = head_old_q;
  assign new_addr_o     = head_new_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_swap_req_queue.sv
// Directed bench for swap_req_queue; build with SWAP_QUEUE_DEDUP_EN to exercise dedup.
module tb_swap_req_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [2:0]  push_idx = '0;
  logic [20:0] push_old = '0;
  logic [20:0] push_new = '0;
  logic        done_in = 1'b0;
  logic        ready, done_out, swap_req;
  logic [2:0]  head_idx;
  logic [20:0] head_old, head_new;
  logic [2:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state
  int          rises = 0;
  int          dones = 0;
  int          low_run = 0;
  logic        prev_req = 1'b0;
  logic [20:0] heads[$];
  int          gaps[$];

  swap_req_queue dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .push_i         (push),
    .push_idx_i     (push_idx),
    .push_old_addr_i(push_old),
    .push_new_addr_i(push_new),
    .ready_o        (ready),
    .done_o         (done_out),
    .swap_req_o     (swap_req),
    .old_addr_idx_o (head_idx),
    .old_addr_o     (head_old),
    .new_addr_o     (head_new),
    .done_i         (done_in),
    .count_o        (count),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (swap_req && !prev_req) begin
      heads.push_back(head_new);
      gaps.push_back(low_run);
      rises++;
    end
    if (swap_req) low_run = 0;
    else low_run++;
    prev_req = swap_req;
    if (done_out) dones++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push = 1'b0;
    done_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [2:0] idx, input logic [20:0] old_a,
                          input logic [20:0] new_a);
    push = 1'b1;
    push_idx = idx;
    push_old = old_a;
    push_new = new_a;
    step();
    push = 1'b0;
  endtask

  // Retires every queued request, answering each swap_req with done_i.
  task automatic drain();
    int cyc = 0;
    while (!(count == 0 && !swap_req) && cyc < 100) begin
      done_in = swap_req && !done_in;
      step();
      cyc++;
    end
    done_in = 1'b0;
    check("drain_timeout", 32'(cyc < 100), 32'd1);
  endtask

  initial begin
    int n_pushed;
    int hi;
    int cyc;
    int r0;
    int d0;

    // Reset state
    do_reset();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_req", 32'(swap_req), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_head", 32'(head_new) | 32'(head_old) | 32'(head_idx), 32'd0);

    // Basic handshake
    repeat (3) step();
    push_one(3'd2, 21'h00010, 21'h00020);
    check("b_count1", 32'(count), 32'd1);
    check("b_req_t1", 32'(swap_req), 32'd0);
    step();
    check("b_req_t2", 32'(swap_req), 32'd1);
    check("b_idx", 32'(head_idx), 32'd2);
    check("b_old", 32'(head_old), 32'h10);
    check("b_new", 32'(head_new), 32'h20);
    step();
    step();
    check("b_req_hold", 32'(swap_req), 32'd1);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("b_req_off", 32'(swap_req), 32'd0);
    check("b_done", 32'(done_out), 32'd1);
    check("b_count0", 32'(count), 32'd0);
    step();
    check("b_done_pulse", 32'(done_out), 32'd0);

    // Order and wrap
    do_reset();
    heads.delete();
    gaps.delete();
    r0 = rises;
    d0 = dones;
    n_pushed = 0;
    hi = 0;
    cyc = 0;
    while ((dones - d0) < 6 && cyc < 300) begin
      push = 1'b0;
      done_in = 1'b0;
      if (n_pushed < 6 && ready) begin
        push = 1'b1;
        push_idx = 3'(n_pushed);
        push_old = 21'(n_pushed);
        push_new = 21'h100 + 21'(n_pushed);
        n_pushed++;
      end
      if (swap_req) hi++;
      else hi = 0;
      if (hi == 3) done_in = 1'b1;
      step();
      cyc++;
    end
    push = 1'b0;
    done_in = 1'b0;
    step();
    step();
    check("o_rises", 32'(rises - r0), 32'd6);
    check("o_dones", 32'(dones - d0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < heads.size()) check("o_head", 32'(heads[i]), 32'h100 + 32'(i));
      if (i > 0 && i < gaps.size()) check("o_gap", 32'(gaps[i]), 32'd1);
    end
    check("o_count", 32'(count), 32'd0);
    check("o_ovf", 32'(overflow), 32'd0);

    // Full and overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_one(3'(i), 21'(i), 21'h200 + 21'(i));
      if (i == 3) begin
        check("f_ready0", 32'(ready), 32'd0);
        check("f_count4", 32'(count), 32'd4);
        check("f_ovf0", 32'(overflow), 32'd0);
      end
    end
    check("f_count_peak", 32'(count), 32'd4);
    check("f_ovf1", 32'(overflow), 32'd1);
    drain();
    check("f_ovf_sticky", 32'(overflow), 32'd1);
    check("f_ready1", 32'(ready), 32'd1);

    // Simultaneous push and retire, full
    do_reset();
    for (int i = 0; i < 4; i++) push_one(3'(i), 21'(i), 21'h200 + 21'(i));
    check("s_busy_full", 32'(swap_req) + 32'(count), 32'd5);
    push = 1'b1;
    push_new = 21'h2FF;
    done_in = 1'b1;
    step();
    push = 1'b0;
    done_in = 1'b0;
    check("s_full_ovf", 32'(overflow), 32'd1);
    check("s_full_count", 32'(count), 32'd3);
    heads.delete();
    drain();
    check("s_full_n", 32'(heads.size()), 32'd3);
    if (heads.size() == 3) check("s_full_last", 32'(heads[2]), 32'h203);

    // Simultaneous push and retire, count 3
    do_reset();
    for (int i = 0; i < 3; i++) push_one(3'(i), 21'(i), 21'h300 + 21'(i));
    check("s3_busy", 32'(swap_req) + 32'(count), 32'd4);
    push = 1'b1;
    push_new = 21'h3FF;
    done_in = 1'b1;
    step();
    push = 1'b0;
    done_in = 1'b0;
    check("s3_count", 32'(count), 32'd3);
    check("s3_ovf", 32'(overflow), 32'd0);
    heads.delete();
    drain();
    check("s3_n", 32'(heads.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < heads.size()) check("s3_order", 32'(heads[i]), (i == 2) ? 32'h3FF : 32'h301 + 32'(i));
    end

    // Reset while BUSY
    do_reset();
    for (int i = 0; i < 4; i++) push_one(3'(i), 21'(i), 21'h400 + 21'(i));
    drain();
    check("r_ovf_pre", 32'(overflow), 32'd0);
    push_one(3'd1, 21'h1, 21'h500);
    push_one(3'd2, 21'h2, 21'h501);
    push_one(3'd3, 21'h3, 21'h502);
    check("r_pre", 32'(swap_req) + 32'(count), 32'd4);
    d0 = dones;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_req", 32'(swap_req), 32'd0);
    check("r_count", 32'(count), 32'd0);
    check("r_ready", 32'(ready), 32'd1);
    check("r_ovf", 32'(overflow), 32'd0);
    done_in = 1'b1;
    repeat (5) step();
    done_in = 1'b0;
    check("r_no_done", 32'(dones - d0), 32'd0);
    check("r_idle", 32'(swap_req), 32'd0);

    // Duplicate new addresses
    do_reset();
    r0 = rises;
    push_one(3'd1, 21'h1, 21'h0ABCD);
    push_one(3'd2, 21'h2, 21'h0ABCD);
    push_one(3'd3, 21'h3, 21'h0ABCE);
`ifdef SWAP_QUEUE_DEDUP_EN
    check("d_count", 32'(count), 32'd2);
`else
    check("d_count", 32'(count), 32'd3);
`endif
    drain();
    step();
`ifdef SWAP_QUEUE_DEDUP_EN
    check("d_rises", 32'(rises - r0), 32'd2);
`else
    check("d_rises", 32'(rises - r0), 32'd3);
`endif
    check("d_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
